// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline-stage register: skid state encoding,
// occupancy constants and default bundle widths for the CPU stage registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    localparam int PIPE_CTRL_W = 8;
    localparam int PIPE_DATA_W = 64;
    localparam int PIPE_CNT_W  = 16;

    function automatic logic [1:0] state_occ(input skid_state_e s);
        logic [1:0] occ;
        occ = OCC_EMPTY;
        case (s)
            ST_ONE:  occ = OCC_ONE;
            ST_TWO:  occ = OCC_TWO;
            default: occ = OCC_EMPTY;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One entry of the stage register (control + data) with load and clear.
// Clear always zeroes control; data is zeroed only when ZERO_DATA is set.
module pipe_slot #(
    parameter int CTRL_W    = 8,
    parameter int DATA_W    = 64,
    parameter int ZERO_DATA = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_ctrl <= '0;
            q_data <= '0;
        end else if (clear) begin
            q_ctrl <= '0;
            if (ZERO_DATA != 0) begin
                q_data <= '0;
            end
        end else if (load) begin
            q_ctrl <= d_ctrl;
            q_data <= d_data;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Generic valid/ready pipeline-stage register with a one-entry skid buffer, flush-to-bubble
// and a saturating stall counter. in_ready is derived only from the state register.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W    = PIPE_CTRL_W,
    parameter int DATA_W    = PIPE_DATA_W,
    parameter int ZERO_DATA = 0,
    parameter int CNT_W     = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    skid_state_e state_q, state_d;

    logic              in_fire, out_fire;
    logic              main_load, main_clr, main_from_skid;
    logic              skid_load, skid_clr;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
    logic [DATA_W-1:0] main_data, skid_data, main_d_data;
    logic [CNT_W-1:0]  stall_q;

    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign occupancy = state_occ(state_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d   = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        state_d   = ST_TWO;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_d  = ST_EMPTY;
                        main_clr = 1'b1;
                    end
                end
                ST_TWO: begin
                    // skid always holds the younger entry, so it moves up into main
                    if (out_fire) begin
                        state_d        = ST_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    assign main_d_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_d_data = main_from_skid ? skid_data : in_data;

    pipe_slot #(
        .CTRL_W    (CTRL_W),
        .DATA_W    (DATA_W),
        .ZERO_DATA (ZERO_DATA)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (main_load),
        .clear  (main_clr),
        .d_ctrl (main_d_ctrl),
        .d_data (main_d_data),
        .q_ctrl (main_ctrl),
        .q_data (main_data)
    );

    pipe_slot #(
        .CTRL_W    (CTRL_W),
        .DATA_W    (DATA_W),
        .ZERO_DATA (ZERO_DATA)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .clear  (skid_clr),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .q_ctrl (skid_ctrl),
        .q_data (skid_data)
    );

    // gate control so a bubble can never leak RegWrite/MemWrite downstream
    assign out_ctrl = out_valid ? main_ctrl : '0;
    assign out_data = main_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: a two-deep FIFO model drives expectations for
// a ZERO_DATA=0 and a ZERO_DATA=1 instance sharing the same stimulus.
module tb_pipe_skid_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_ctrl = '0;
    logic [63:0] in_data = '0;

    logic        in_ready, out_valid, in_ready_z, out_valid_z;
    logic [7:0]  out_ctrl, out_ctrl_z;
    logic [63:0] out_data, out_data_z;
    logic [1:0]  occupancy, occupancy_z;
    logic [3:0]  stall_cnt, stall_cnt_z;

    typedef struct {
        logic [7:0]  c;
        logic [63:0] d;
    } ent_t;

    ent_t       sb[$];
    logic [3:0] stall_exp;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.CTRL_W(8), .DATA_W(64), .ZERO_DATA(0), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_skid_stage #(.CTRL_W(8), .DATA_W(64), .ZERO_DATA(1), .CNT_W(4)) dut_z (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_z),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_z), .out_ready(out_ready),
        .out_ctrl(out_ctrl_z), .out_data(out_data_z), .occupancy(occupancy_z),
        .stall_cnt(stall_cnt_z)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int n;
        n = sb.size();
        check_val("in_ready", {63'd0, in_ready}, {63'd0, n != 2});
        check_val("out_valid", {63'd0, out_valid}, {63'd0, n != 0});
        check_val("occupancy", {62'd0, occupancy}, 64'(n));
        check_val("stall_cnt", {60'd0, stall_cnt}, {60'd0, stall_exp});
        check_val("out_ctrl", {56'd0, out_ctrl}, (n != 0) ? {56'd0, sb[0].c} : 64'd0);
        check_val("z_out_ctrl", {56'd0, out_ctrl_z}, (n != 0) ? {56'd0, sb[0].c} : 64'd0);
        check_val("z_out_data", out_data_z, (n != 0) ? sb[0].d : 64'd0);
        check_val("z_occupancy", {62'd0, occupancy_z}, 64'(n));
        if (n != 0) begin
            check_val("out_data", out_data, sb[0].d);
        end
    endtask

    task automatic cycle(input logic iv, input logic [7:0] ic, input logic [63:0] id,
                         input logic ordy, input logic fl);
        ent_t e;
        logic ov, ir;
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_outputs();
        ov = (sb.size() != 0);
        ir = (sb.size() != 2);
        if (ov && !ordy && stall_exp != 4'hF) stall_exp = stall_exp + 4'd1;
        if (fl) begin
            sb.delete();
        end else begin
            if (ov && ordy) void'(sb.pop_front());
            if (iv && ir) begin
                e.c = ic;
                e.d = id;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        check_val({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        check_val({tag, "_out_ctrl"}, {56'd0, out_ctrl}, 64'd0);
        check_val({tag, "_out_data"}, out_data, 64'd0);
        check_val({tag, "_occupancy"}, {62'd0, occupancy}, 64'd0);
        check_val({tag, "_stall_cnt"}, {60'd0, stall_cnt}, 64'd0);
    endtask

    initial begin
        logic [7:0] stream[4];
        stream[0] = 8'hA5; stream[1] = 8'h3C; stream[2] = 8'h5A; stream[3] = 8'hC3;
        stall_exp = 4'd0;

        // reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        // streaming
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, stream[i], 64'h1000 + 64'(i), 1'b1, 1'b0);
        end
        cycle(1'b0, 8'h00, 64'd0, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 64'd0, 1'b1, 1'b0);

        // skid fill, one dropped offer while full, then ordered drain
        cycle(1'b1, 8'h11, 64'hAAAA_0001, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 64'hBBBB_0002, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 64'hCCCC_0003, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 64'd0, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 64'd0, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 64'd0, 1'b1, 1'b0);

        // drained bubble: data holds last value only without ZERO_DATA
        check_val("drain_out_data", out_data, 64'hBBBB_0002);
        check_val("drain_z_out_data", out_data_z, 64'd0);
        check_val("drain_out_ctrl", {56'd0, out_ctrl}, 64'd0);

        // long stall saturates the counter
        cycle(1'b1, 8'h44, 64'hDDDD_0004, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 64'd0, 1'b0, 1'b0);
        check_val("stall_sat", {60'd0, stall_cnt}, 64'hF);

        // flush at occupancy 2 with a live offer
        cycle(1'b1, 8'h55, 64'hEEEE_0005, 1'b0, 1'b0);
        cycle(1'b1, 8'h66, 64'hFFFF_0006, 1'b0, 1'b1);
        check_val("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("flush_occupancy", {62'd0, occupancy}, 64'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 64'd0, 1'b1, 1'b0);
        check_val("flush_keeps_stall", {60'd0, stall_cnt}, 64'hF);

        // async reset while full
        cycle(1'b1, 8'h77, 64'h7777, 1'b0, 1'b0);
        cycle(1'b1, 8'h88, 64'h8888, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("midrst");
        sb.delete();
        stall_exp = 4'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // random traffic
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), {$urandom, $urandom},
                  1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
